// File: rtl/lcg_stream_checker.sv
// Checks an incoming word stream against a linear congruential generator.
// The first accepted word seeds the predictor; mismatches resync and are counted until FAULT.
//   state    | meaning
//   S_IDLE   | waiting for a seed word
//   S_LOCKED | predicting and comparing each accepted word
//   S_FAULT  | error limit reached, input stalled until clear
module lcg_stream_checker #(
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned MULT      = 32'd1103515245,
  parameter int unsigned INC       = 32'd12345,
  parameter int unsigned CNT_WDTH  = 16,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WDTH-1:0] in_data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 mismatch,
  output logic [DATA_WDTH-1:0] expected,
  output logic [CNT_WDTH-1:0]  match_count,
  output logic [CNT_WDTH-1:0]  err_count,
  output logic                 fault
);

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_FAULT} state_t;

  localparam logic [DATA_WDTH-1:0] C_MULT  = DATA_WDTH'(MULT);
  localparam logic [DATA_WDTH-1:0] C_INC   = DATA_WDTH'(INC);
  localparam logic [CNT_WDTH:0]    C_LIMIT = (CNT_WDTH+1)'(ERR_LIMIT);
  localparam logic [CNT_WDTH-1:0]  C_MAX   = '1;

  state_t               r_state, w_state_nx;
  logic [DATA_WDTH-1:0] r_expected, w_expected_nx;
  logic [CNT_WDTH-1:0]  r_match, w_match_nx;
  logic [CNT_WDTH-1:0]  r_err, w_err_nx;
  logic                 r_mismatch, w_mismatch_nx;
  logic                 r_locked, r_fault;
  logic                 w_accept;
  logic [DATA_WDTH-1:0] w_lcg_next;
  logic [CNT_WDTH:0]    w_err_inc;

  assign in_ready   = (r_state != S_FAULT);
  assign w_accept   = in_valid & in_ready;
  // Multiply and add at DATA_WDTH bits so the result wraps mod 2^DATA_WDTH.
  assign w_lcg_next = in_data * C_MULT + C_INC;
  assign w_err_inc  = {1'b0, r_err} + 1'b1;

  always_comb begin
    w_state_nx    = r_state;
    w_expected_nx = r_expected;
    w_match_nx    = r_match;
    w_err_nx      = r_err;
    w_mismatch_nx = 1'b0;
    if (clear) begin
      w_state_nx    = S_IDLE;
      w_expected_nx = '0;
      w_match_nx    = '0;
      w_err_nx      = '0;
    end else if (w_accept) begin
      w_expected_nx = w_lcg_next;
      case (r_state)
        S_IDLE: w_state_nx = S_LOCKED;
        S_LOCKED: begin
          if (in_data == r_expected) begin
            if (r_match != C_MAX) w_match_nx = r_match + 1'b1;
          end else begin
            w_mismatch_nx = 1'b1;
            if (r_err != C_MAX) w_err_nx = r_err + 1'b1;
            if (w_err_inc >= C_LIMIT) w_state_nx = S_FAULT;
          end
        end
        default: begin
          w_state_nx    = r_state;
          w_expected_nx = r_expected;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_expected <= '0;
      r_match    <= '0;
      r_err      <= '0;
      r_mismatch <= 1'b0;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_expected <= w_expected_nx;
      r_match    <= w_match_nx;
      r_err      <= w_err_nx;
      r_mismatch <= w_mismatch_nx;
      r_locked   <= (w_state_nx == S_LOCKED);
      r_fault    <= (w_state_nx == S_FAULT);
    end
  end

  assign locked      = r_locked;
  assign fault       = r_fault;
  assign mismatch    = r_mismatch;
  assign expected    = r_expected;
  assign match_count = r_match;
  assign err_count   = r_err;

endmodule
